// File: rtl/shifter_arbiter.sv
// Two-requester arbiter in front of one shared shifter/extender.
// IDLE picks a winner, EXEC captures the shared unit's result, DONE holds it until the consumer acks.
module shifter_arbiter #(
   parameter bit RR_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0,
   input  logic        req1,
   input  logic [31:0] op0,
   input  logic [31:0] op1,
   input  logic [5:0]  amt0,
   input  logic [5:0]  amt1,
   input  logic [2:0]  typ0,
   input  logic [2:0]  typ1,
   input  logic        ext0,
   input  logic        ext1,
   output logic        gnt0,
   output logic        gnt1,
   output logic [31:0] sh_in,
   output logic [5:0]  sh_amt,
   output logic [2:0]  sh_t,
   output logic        sh_E,
   input  logic [31:0] sh_out,
   output logic [31:0] res,
   output logic        res_valid,
   output logic        res_err,
   output logic        res_id,
   input  logic        res_ack,
   output logic        busy,
   output logic [1:0]  state_dbg
);

   // Result handshake: res/res_err/res_id are meaningful while res_valid is high and
   // stay frozen until a clock edge sees res_valid && res_ack; res_ack is ignored otherwise.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        gnt0_q, gnt0_d;
   logic        gnt1_q, gnt1_d;
   logic [31:0] sh_in_q, sh_in_d;
   logic [5:0]  sh_amt_q, sh_amt_d;
   logic [2:0]  sh_t_q, sh_t_d;
   logic        sh_e_q, sh_e_d;
   logic [31:0] res_q, res_d;
   logic        res_valid_q, res_valid_d;
   logic        res_err_q, res_err_d;
   logic        res_id_q, res_id_d;
   logic        busy_q, busy_d;
   logic        last_q, last_d;

   logic        pick1;
   logic        illegal;

   // Requester 1 wins when alone, or on a round-robin tie when 0 was granted last.
   assign pick1   = !req0 || (req1 && RR_EN && !last_q);
   assign illegal = sh_e_q ? (sh_t_q >= 3'd6) : (sh_t_q == 3'd7);

   always_comb begin
      state_d     = state_q;
      gnt0_d      = 1'b0;
      gnt1_d      = 1'b0;
      sh_in_d     = sh_in_q;
      sh_amt_d    = sh_amt_q;
      sh_t_d      = sh_t_q;
      sh_e_d      = sh_e_q;
      res_d       = res_q;
      res_valid_d = res_valid_q;
      res_err_d   = res_err_q;
      res_id_d    = res_id_q;
      busy_d      = busy_q;
      last_d      = last_q;

      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               state_d  = EXEC;
               busy_d   = 1'b1;
               gnt0_d   = !pick1;
               gnt1_d   = pick1;
               res_id_d = pick1;
               last_d   = pick1;
               sh_in_d  = pick1 ? op1  : op0;
               sh_amt_d = pick1 ? amt1 : amt0;
               sh_t_d   = pick1 ? typ1 : typ0;
               sh_e_d   = pick1 ? ext1 : ext0;
            end
         end
         EXEC: begin
            state_d     = DONE;
            res_d       = illegal ? 32'd0 : sh_out;
            res_err_d   = illegal;
            res_valid_d = 1'b1;
         end
         DONE: begin
            if (res_ack) begin
               state_d     = IDLE;
               res_valid_d = 1'b0;
               busy_d      = 1'b0;
            end
         end
         default: begin
            state_d     = IDLE;
            res_valid_d = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         sh_in_q     <= 32'd0;
         sh_amt_q    <= 6'd0;
         sh_t_q      <= 3'd0;
         sh_e_q      <= 1'b0;
         res_q       <= 32'd0;
         res_valid_q <= 1'b0;
         res_err_q   <= 1'b0;
         res_id_q    <= 1'b0;
         busy_q      <= 1'b0;
         last_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         gnt0_q      <= gnt0_d;
         gnt1_q      <= gnt1_d;
         sh_in_q     <= sh_in_d;
         sh_amt_q    <= sh_amt_d;
         sh_t_q      <= sh_t_d;
         sh_e_q      <= sh_e_d;
         res_q       <= res_d;
         res_valid_q <= res_valid_d;
         res_err_q   <= res_err_d;
         res_id_q    <= res_id_d;
         busy_q      <= busy_d;
         last_q      <= last_d;
      end
   end

   assign gnt0      = gnt0_q;
   assign gnt1      = gnt1_q;
   assign sh_in     = sh_in_q;
   assign sh_amt    = sh_amt_q;
   assign sh_t      = sh_t_q;
   assign sh_E      = sh_e_q;
   assign res       = res_q;
   assign res_valid = res_valid_q;
   assign res_err   = res_err_q;
   assign res_id    = res_id_q;
   assign busy      = busy_q;
   assign state_dbg = state_q;

endmodule
